// File: rtl/mod_vga_timing.sv
// 640x480@60 VGA raster timing generator: free-running h/v counters with
// registered sync, display-enable, pixel coordinates and frame/line/vblank strobes.
module mod_vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk_in_25_175_mhz,
  input  logic       rst_n_in,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       frame_start_out,
  output logic       line_start_out,
  output logic       vblank_start_out
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_h_vis;
  logic       w_v_vis;
  logic       w_de;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_h_zero;
  logic       w_frame_start;
  logic       w_line_start;
  logic       w_vblank_start;

  // Raster position counters; the frame wrap is handled in the same cycle as the line wrap.
  always_ff @(posedge clk_in_25_175_mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  always_comb begin
    w_h_last       = (r_h_cnt == H_LAST);
    w_v_last       = (r_v_cnt == V_LAST);
    w_h_vis        = (r_h_cnt < H_ACT_END);
    w_v_vis        = (r_v_cnt < V_ACT_END);
    w_de           = w_h_vis && w_v_vis;
    w_hs_act       = (r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_END);
    w_vs_act       = (r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_END);
    w_h_zero       = (r_h_cnt == '0);
    w_frame_start  = w_h_zero && (r_v_cnt == '0);
    w_line_start   = w_h_zero && w_v_vis;
    w_vblank_start = w_h_zero && (r_v_cnt == V_ACT_END);
  end

  // Outputs are decoded from the pre-increment position, so each lags the counters by one edge.
  always_ff @(posedge clk_in_25_175_mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hsync_out        <= SYNC_IDLE;
      vsync_out        <= SYNC_IDLE;
      de_out           <= 1'b0;
      x_out            <= '0;
      y_out            <= '0;
      frame_start_out  <= 1'b0;
      line_start_out   <= 1'b0;
      vblank_start_out <= 1'b0;
    end else begin
      hsync_out        <= w_hs_act ? SYNC_ACT : SYNC_IDLE;
      vsync_out        <= w_vs_act ? SYNC_ACT : SYNC_IDLE;
      de_out           <= w_de;
      x_out            <= w_de ? r_h_cnt : '0;
      y_out            <= w_de ? r_v_cnt : '0;
      frame_start_out  <= w_frame_start;
      line_start_out   <= w_line_start;
      vblank_start_out <= w_vblank_start;
    end
  end

endmodule

// File: tb/tb_mod_vga_timing.sv
// Scoreboard bench for mod_vga_timing: a linear-position raster model queues the expected
// output per edge, and a negedge monitor compares; default and reduced rasters run together.
module tb_mod_vga_timing;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       ls;
    logic       vb;
  } vga_t;

  localparam vga_t RESET_VAL = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 10'd0, y: 10'd0,
                                 fs: 1'b0, ls: 1'b0, vb: 1'b0};

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  bit   done_a = 1'b0;
  bit   done_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_de, a_fs, a_ls, a_vb;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_de, b_fs, b_ls, b_vb;
  logic [9:0] b_x, b_y;
  vga_t       out_a, out_b;

  assign out_a = '{hs: a_hs, vs: a_vs, de: a_de, x: a_x, y: a_y, fs: a_fs, ls: a_ls, vb: a_vb};
  assign out_b = '{hs: b_hs, vs: b_vs, de: b_de, x: b_x, y: b_y, fs: b_fs, ls: b_ls, vb: b_vb};

  mod_vga_timing u_dut_a (
    .clk_in_25_175_mhz (clk),
    .rst_n_in          (rst_a),
    .hsync_out         (a_hs),
    .vsync_out         (a_vs),
    .de_out            (a_de),
    .x_out             (a_x),
    .y_out             (a_y),
    .frame_start_out   (a_fs),
    .line_start_out    (a_ls),
    .vblank_start_out  (a_vb)
  );

  mod_vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (2),
    .SYNC_POL (1'b0)
  ) u_dut_b (
    .clk_in_25_175_mhz (clk),
    .rst_n_in          (rst_b),
    .hsync_out         (b_hs),
    .vsync_out         (b_vs),
    .de_out            (b_de),
    .x_out             (b_x),
    .y_out             (b_y),
    .frame_start_out   (b_fs),
    .line_start_out    (b_ls),
    .vblank_start_out  (b_vb)
  );

  // Expected outputs for the p-th position in raster order (p counts from 0 after reset).
  function automatic vga_t model(input int unsigned p,
                                 input int unsigned ha, input int unsigned hf,
                                 input int unsigned hw, input int unsigned hb,
                                 input int unsigned va, input int unsigned vf,
                                 input int unsigned vw, input int unsigned vb);
    vga_t        e;
    int unsigned ht, vt, h, v;
    ht   = ha + hf + hw + hb;
    vt   = va + vf + vw + vb;
    h    = p % ht;
    v    = (p / ht) % vt;
    e.de = (h < ha) && (v < va);
    e.x  = e.de ? 10'(h) : 10'd0;
    e.y  = e.de ? 10'(v) : 10'd0;
    e.hs = !((h >= ha + hf) && (h < ha + hf + hw));
    e.vs = !((v >= va + vf) && (v < va + vf + vw));
    e.fs = (h == 0) && (v == 0);
    e.ls = (h == 0) && (v < va);
    e.vb = (h == 0) && (v == va);
    return e;
  endfunction

  task automatic compare(input string name, input vga_t act, input vga_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b vb=%b required hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b vb=%b",
               name, $time, act.hs, act.vs, act.de, act.x, act.y, act.fs, act.ls, act.vb,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.fs, exp.ls, exp.vb);
    end
  endtask

  vga_t        q_a[$];
  vga_t        q_b[$];
  int unsigned pos_a = 0;
  int unsigned pos_b = 0;

  // Expected-response producers: one queue entry per rising edge.
  always @(posedge clk) begin
    if (!rst_a) begin
      q_a.push_back(RESET_VAL);
      pos_a = 0;
    end else begin
      q_a.push_back(model(pos_a, 640, 16, 96, 48, 480, 10, 2, 33));
      pos_a++;
    end
    if (!rst_b) begin
      q_b.push_back(RESET_VAL);
      pos_b = 0;
    end else begin
      q_b.push_back(model(pos_b, 8, 2, 3, 3, 4, 1, 1, 2));
      pos_b++;
    end
  end

  always @(negedge clk) begin
    vga_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      compare("raster_640x480", out_a, e);
    end
  end

  always @(negedge clk) begin
    vga_t e;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare("raster_16x8", out_b, e);
    end
  end

  // Inputs change 2 time units after the falling edge, clear of both sample points.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin : stim_a
    repeat (10) step();
    #1 compare("a_reset_held", out_a, RESET_VAL);
    rst_a = 1'b1;
    repeat (12345) step();
    rst_a = 1'b0;
    #1 compare("a_async_reset", out_a, RESET_VAL);
    repeat ($urandom_range(3, 12)) step();
    rst_a = 1'b1;
    repeat (2000) step();
    done_a = 1'b1;
  end

  initial begin : stim_b
    repeat (10) step();
    #1 compare("b_reset_held", out_b, RESET_VAL);
    rst_b = 1'b1;
    repeat (3 * 128 + 5) step();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 400)) step();
      rst_b = 1'b0;
      #1 compare("b_async_reset", out_b, RESET_VAL);
      repeat ($urandom_range(1, 5)) step();
      rst_b = 1'b1;
    end
    repeat (2 * 128 + 3) step();
    done_b = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done_a && done_b);
      begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout actual done_a=%b done_b=%b required both 1", done_a, done_b);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
